// File: rtl/op_sequencer_arb.sv
// Shares one datapath between requesters A and B: arbitrate, LOAD, EXEC (N steps), WRITE, DONE; ROUND_ROBIN_EN selects round-robin ties.
// Ack to Done is N+3 cycles; requests are sampled only in IDLE, so a requester waits (no Ack) while Busy.
module op_sequencer_arb #(
   parameter int WIDTH      = 8,
   parameter int MUL_CYCLES = 8
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             ReqA,
   input  logic [3:0]       OpA,
   input  logic [WIDTH-1:0] Input1A,
   input  logic [WIDTH-1:0] Input2A,
   input  logic             ReqB,
   input  logic [3:0]       OpB,
   input  logic [WIDTH-1:0] Input1B,
   input  logic [WIDTH-1:0] Input2B,
   output logic             AckA,
   output logic             AckB,
   output logic [WIDTH-1:0] Dp_Op1,
   output logic [WIDTH-1:0] Dp_Op2,
   output logic [3:0]       Dp_Opc,
   output logic             Dp_Clr,
   output logic             Dp_Step,
   input  logic [WIDTH-1:0] Dp_Result,
   output logic [WIDTH-1:0] Result,
   output logic             ResultId,
   output logic             Done,
   output logic             Err,
   output logic             Busy
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXEC, S_WRITE, S_DONE} state_t;

   state_t     state;
   state_t     next_state;
   logic [3:0] cnt;
   logic [3:0] load_n;
   logic       illegal;
   logic       err_flag;
   logic       owner_b;
   logic       grant_a;
   logic       grant_b;
   logic       take;
`ifdef ROUND_ROBIN_EN
   logic       last_b;
`endif

   // Grants exist only in IDLE and are suppressed while Reset is high.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (state == S_IDLE && !Reset) begin
`ifdef ROUND_ROBIN_EN
         grant_a = ReqA && (!ReqB || last_b);
`else
         grant_a = ReqA;
`endif
         grant_b = ReqB && !grant_a;
      end
      take = grant_a || grant_b;
   end

   always_comb begin
      illegal = 1'b0;
      load_n  = 4'd0;
      if (Dp_Opc <= 4'd5)
         load_n = 4'd1;
      else if (Dp_Opc <= 4'd8)
         load_n = {1'b0, Dp_Op2[2:0]};
      else if (Dp_Opc == 4'd9)
         load_n = 4'(MUL_CYCLES);
      else
         illegal = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (Reset)
         state <= S_IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (take) next_state = S_LOAD;
         S_LOAD:  next_state = (load_n == 4'd0) ? S_WRITE : S_EXEC;
         S_EXEC:  if (cnt <= 4'd1) next_state = S_WRITE;
         S_WRITE: next_state = S_DONE;
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_comb begin
      AckA    = grant_a;
      AckB    = grant_b;
      Dp_Clr  = (state == S_LOAD);
      Dp_Step = (state == S_EXEC);
      Done    = (state == S_DONE);
      Busy    = (state != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         Dp_Opc   <= '0;
         Dp_Op1   <= '0;
         Dp_Op2   <= '0;
         owner_b  <= 1'b0;
         cnt      <= '0;
         err_flag <= 1'b0;
         Result   <= '0;
         ResultId <= 1'b0;
         Err      <= 1'b0;
`ifdef ROUND_ROBIN_EN
         last_b   <= 1'b1;
`endif
      end else begin
         if (take) begin
            Dp_Opc  <= grant_b ? OpB : OpA;
            Dp_Op1  <= grant_b ? Input1B : Input1A;
            Dp_Op2  <= grant_b ? Input2B : Input2A;
            owner_b <= grant_b;
`ifdef ROUND_ROBIN_EN
            last_b  <= grant_b;
`endif
         end
         case (state)
            S_LOAD: begin
               cnt      <= load_n;
               err_flag <= illegal;
            end
            S_EXEC:  cnt <= cnt - 4'd1;
            S_WRITE: begin
               // An illegal opcode leaves the previous result visible.
               if (!err_flag) Result <= Dp_Result;
               ResultId <= owner_b;
               Err      <= err_flag;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_op_sequencer_arb.sv
// Bench for op_sequencer_arb: directed scenarios plus random back-to-back traffic against a transaction-level model.
module tb_op_sequencer_arb;

   logic       clk = 1'b0;
   logic       Reset;
   logic       ReqA, ReqB;
   logic [3:0] OpA, OpB;
   logic [7:0] Input1A, Input2A, Input1B, Input2B;
   logic       AckA, AckB;
   logic [7:0] Dp_Op1, Dp_Op2;
   logic [3:0] Dp_Opc;
   logic       Dp_Clr, Dp_Step;
   logic [7:0] Dp_Result;
   logic [7:0] Result;
   logic       ResultId, Done, Err, Busy;

   int checks = 0;
   int failures = 0;
   bit last_b;
   logic [7:0] prev_res;

   always #5 clk = ~clk;

   op_sequencer_arb dut (
      .clk(clk), .Reset(Reset),
      .ReqA(ReqA), .OpA(OpA), .Input1A(Input1A), .Input2A(Input2A),
      .ReqB(ReqB), .OpB(OpB), .Input1B(Input1B), .Input2B(Input2B),
      .AckA(AckA), .AckB(AckB),
      .Dp_Op1(Dp_Op1), .Dp_Op2(Dp_Op2), .Dp_Opc(Dp_Opc),
      .Dp_Clr(Dp_Clr), .Dp_Step(Dp_Step), .Dp_Result(Dp_Result),
      .Result(Result), .ResultId(ResultId), .Done(Done), .Err(Err), .Busy(Busy)
   );

   // Behavioural ALU: final datapath answer for an opcode; 8'hEE stands in for garbage on illegal opcodes.
   function automatic logic [7:0] ref_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      logic signed [7:0] sa;
      logic [15:0] prod;
      sa = a;
      prod = a * b;
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return ~a;
         4'd6: return 8'(sa >>> b[2:0]);
         4'd7: return a << b[2:0];
         4'd8: return a >> b[2:0];
         4'd9: return prod[7:0];
         default: return 8'hEE;
      endcase
   endfunction

   function automatic int ref_n(input logic [3:0] op, input logic [7:0] b);
      if (op <= 4'd5) return 1;
      if (op <= 4'd8) return int'(b[2:0]);
      if (op == 4'd9) return 8;
      return 0;
   endfunction

   function automatic bit tie_winner();
`ifdef ROUND_ROBIN_EN
      return !last_b;
`else
      return 1'b0;
`endif
   endfunction

   always_comb Dp_Result = ref_alu(Dp_Opc, Dp_Op1, Dp_Op2);

   // Runs one transaction from an IDLE cycle and records what was observed; leaves the bench in the drive phase.
   task automatic do_txn(input logic [1:0] req, input logic [3:0] opa, input logic [3:0] opb,
                         input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] b1, input logic [7:0] b2,
                         input bit hold_loser, output int ack_at, output bit win_b, output int n_ack,
                         output int steps, output int clrs, output int done_at, output bit lat_bad);
      ack_at = -1; win_b = 0; n_ack = 0; steps = 0; clrs = 0; done_at = -1; lat_bad = 0;
      ReqA = req[0]; ReqB = req[1];
      OpA = opa; Input1A = a1; Input2A = a2;
      OpB = opb; Input1B = b1; Input2B = b2;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         n_ack += int'(AckA) + int'(AckB);
         if ((AckA || AckB) && ack_at < 0) begin
            ack_at = k;
            win_b = AckB;
         end
         if (Dp_Step) steps++;
         if (Dp_Clr) clrs++;
         if (Busy && ack_at >= 0 &&
             {Dp_Opc, Dp_Op1, Dp_Op2} !== (win_b ? {opb, b1, b2} : {opa, a1, a2}))
            lat_bad = 1;
         if (Done) begin
            done_at = k;
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
         if (k == ack_at) begin
            if (win_b) begin
               ReqB = 0; OpB = 4'($urandom); Input1B = 8'($urandom); Input2B = 8'($urandom);
               if (!hold_loser) ReqA = 0;
            end else begin
               ReqA = 0; OpA = 4'($urandom); Input1A = 8'($urandom); Input2A = 8'($urandom);
               if (!hold_loser) ReqB = 0;
            end
         end
      end
      if (done_at < 0) begin
         ReqA = 0; ReqB = 0;
      end
   endtask

   task automatic test_reset;
      Reset = 1; ReqA = 1; ReqB = 1;
      OpA = 4'($urandom); OpB = 4'($urandom);
      Input1A = 8'($urandom); Input2A = 8'($urandom); Input1B = 8'($urandom); Input2B = 8'($urandom);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({AckA, AckB, Busy, Done, Dp_Clr, Dp_Step} !== 6'b0) begin
         failures++; $display("FAIL reset_ctrl got=%b exp=000000", {AckA, AckB, Busy, Done, Dp_Clr, Dp_Step});
      end
      checks++;
      if ({Result, ResultId, Err} !== 10'b0) begin
         failures++; $display("FAIL reset_result got=%h exp=0", {Result, ResultId, Err});
      end
      checks++;
      if ({Dp_Opc, Dp_Op1, Dp_Op2} !== 20'b0) begin
         failures++; $display("FAIL reset_latch got=%h exp=0", {Dp_Opc, Dp_Op1, Dp_Op2});
      end
      @(posedge clk); #1;
      Reset = 0; ReqA = 0; ReqB = 0;
      last_b = 1; prev_res = 8'h00;
      @(negedge clk);
      checks++;
      if (Busy !== 1'b0) begin
         failures++; $display("FAIL idle_no_req busy got=%b exp=0", Busy);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_add;
      int ack_at, n_ack, steps, clrs, done_at;
      bit win_b, lat_bad;
      do_txn(2'b01, 4'd0, 4'd0, 8'h05, 8'h03, 8'h00, 8'h00, 0, ack_at, win_b, n_ack, steps, clrs, done_at, lat_bad);
      checks++;
      if (ack_at !== 0 || win_b !== 1'b0) begin
         failures++; $display("FAIL add_ack got=%0d/%0d exp=0/0", ack_at, win_b);
      end
      checks++;
      if (steps !== 1 || done_at !== 4) begin
         failures++; $display("FAIL add_timing steps=%0d done=%0d exp=1/4", steps, done_at);
      end
      checks++;
      if ({Result, ResultId, Err} !== {8'h08, 1'b0, 1'b0}) begin
         failures++; $display("FAIL add_result got=%h/%b/%b exp=08/0/0", Result, ResultId, Err);
      end
      last_b = 0; prev_res = 8'h08;
   endtask

   task automatic test_illegal;
      int ack_at, n_ack, steps, clrs, done_at;
      bit win_b, lat_bad;
      do_txn(2'b01, 4'hC, 4'd0, 8'h11, 8'h22, 8'h00, 8'h00, 0, ack_at, win_b, n_ack, steps, clrs, done_at, lat_bad);
      checks++;
      if (steps !== 0 || done_at !== 3) begin
         failures++; $display("FAIL illegal_timing steps=%0d done=%0d exp=0/3", steps, done_at);
      end
      checks++;
      if ({Result, ResultId, Err} !== {prev_res, 1'b0, 1'b1}) begin
         failures++; $display("FAIL illegal_result got=%h/%b/%b exp=%h/0/1", Result, ResultId, Err, prev_res);
      end
      last_b = 0;
   endtask

   task automatic test_shift;
      int ack_at, n_ack, steps, clrs, done_at;
      bit win_b, lat_bad;
      do_txn(2'b10, 4'd0, 4'd6, 8'h00, 8'h00, 8'h80, 8'h03, 0, ack_at, win_b, n_ack, steps, clrs, done_at, lat_bad);
      checks++;
      if (ack_at !== 0 || win_b !== 1'b1 || steps !== 3 || done_at !== 6) begin
         failures++; $display("FAIL sra3_timing ack=%0d b=%0d steps=%0d done=%0d exp=0/1/3/6", ack_at, win_b, steps, done_at);
      end
      checks++;
      if ({Result, ResultId, Err} !== {8'hF0, 1'b1, 1'b0}) begin
         failures++; $display("FAIL sra3_result got=%h/%b/%b exp=f0/1/0", Result, ResultId, Err);
      end
      do_txn(2'b10, 4'd0, 4'd6, 8'h00, 8'h00, 8'h80, 8'h00, 0, ack_at, win_b, n_ack, steps, clrs, done_at, lat_bad);
      checks++;
      if (steps !== 0 || done_at !== 3) begin
         failures++; $display("FAIL sra0_timing steps=%0d done=%0d exp=0/3", steps, done_at);
      end
      checks++;
      if ({Result, ResultId} !== {8'h80, 1'b1}) begin
         failures++; $display("FAIL sra0_result got=%h/%b exp=80/1", Result, ResultId);
      end
      last_b = 1; prev_res = 8'h80;
   endtask

   task automatic test_arb;
      int ack_at, n_ack, steps, clrs, done_at;
      bit win_b, lat_bad, exp_b;
      logic [3:0] opa, opb;
      logic [7:0] a1, a2, b1, b2, exp_res;
      for (int r = 0; r < 2; r++) begin
         opa = 4'($urandom_range(0, 9)); opb = 4'($urandom_range(0, 9));
         a1 = 8'($urandom); a2 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
         exp_b = tie_winner();
         exp_res = exp_b ? ref_alu(opb, b1, b2) : ref_alu(opa, a1, a2);
         do_txn(2'b11, opa, opb, a1, a2, b1, b2, (r == 0), ack_at, win_b, n_ack, steps, clrs, done_at, lat_bad);
         checks++;
         if (ack_at !== 0 || win_b !== exp_b || n_ack !== 1) begin
            failures++; $display("FAIL arb_round%0d ack=%0d winner_b=%0d acks=%0d exp=0/%0d/1", r, ack_at, win_b, n_ack, exp_b);
         end
         checks++;
         if ({Result, ResultId} !== {exp_res, exp_b} || lat_bad) begin
            failures++; $display("FAIL arb_result%0d got=%h/%b latch_bad=%0d exp=%h/%b", r, Result, ResultId, lat_bad, exp_res, exp_b);
         end
         last_b = exp_b; prev_res = exp_res;
      end
   endtask

   task automatic test_drop;
      int ack_a, ack_b, steps, done_at;
      bit idle_busy;
      ack_a = 0; ack_b = 0; steps = 0; done_at = -1; idle_busy = 1;
      ReqA = 1; OpA = 4'd9; Input1A = 8'd3; Input2A = 8'd7; ReqB = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         ack_a += int'(AckA); ack_b += int'(AckB);
         if (Dp_Step) steps++;
         if (Done && done_at < 0) done_at = k;
         if (done_at >= 0 && k == done_at + 2) begin
            idle_busy = Busy;
            break;
         end
         @(posedge clk); #1;
         if (k == 0) ReqA = 0;
         if (k == 2) begin
            ReqB = 1; OpB = 4'd1; Input1B = 8'($urandom); Input2B = 8'($urandom);
         end
         if (k == 5) ReqB = 0;
      end
      @(posedge clk); #1;
      checks++;
      if (ack_b !== 0 || ack_a !== 1) begin
         failures++; $display("FAIL drop_acks ackA=%0d ackB=%0d exp=1/0", ack_a, ack_b);
      end
      checks++;
      if (steps !== 8 || done_at !== 11 || idle_busy !== 1'b0) begin
         failures++; $display("FAIL drop_timing steps=%0d done=%0d busy_after=%0d exp=8/11/0", steps, done_at, idle_busy);
      end
      checks++;
      if ({Result, ResultId, Err} !== {8'd21, 1'b0, 1'b0}) begin
         failures++; $display("FAIL drop_result got=%h/%b/%b exp=15/0/0", Result, ResultId, Err);
      end
      last_b = 0; prev_res = 8'd21;
   endtask

   task automatic test_reset_mid;
      int ack_at, n_ack, steps, clrs, done_at;
      bit win_b, lat_bad, hit;
      steps = 0; hit = 0;
      ReqA = 1; OpA = 4'd9; Input1A = 8'd2; Input2A = 8'd5;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (Dp_Step) steps++;
         if (Done) break;
         if (steps == 4) begin
            hit = 1; Reset = 1;
            break;
         end
         @(posedge clk); #1;
         if (k == 0) ReqA = 0;
      end
      @(posedge clk); #1;
      Reset = 0; ReqA = 0;
      @(negedge clk);
      checks++;
      if (!hit || {AckA, AckB, Busy, Done, Dp_Clr, Dp_Step} !== 6'b0) begin
         failures++; $display("FAIL midreset_ctrl hit=%0d got=%b exp=000000", hit, {AckA, AckB, Busy, Done, Dp_Clr, Dp_Step});
      end
      checks++;
      if ({Result, ResultId, Err, Dp_Opc, Dp_Op1, Dp_Op2} !== 30'b0) begin
         failures++; $display("FAIL midreset_regs got=%h exp=0", {Result, ResultId, Err, Dp_Opc, Dp_Op1, Dp_Op2});
      end
      @(posedge clk); #1;
      last_b = 1; prev_res = 8'h00;
      do_txn(2'b01, 4'd2, 4'd0, 8'hF0, 8'h3C, 8'h00, 8'h00, 0, ack_at, win_b, n_ack, steps, clrs, done_at, lat_bad);
      checks++;
      if (ack_at !== 0 || done_at !== 4 || Result !== 8'h30) begin
         failures++; $display("FAIL midreset_next ack=%0d done=%0d res=%h exp=0/4/30", ack_at, done_at, Result);
      end
      last_b = 0; prev_res = 8'h30;
   endtask

   task automatic test_back_to_back;
      int ack_at, n_ack, steps, clrs, done_at, n;
      bit win_b, lat_bad, exp_b, legal;
      logic [1:0] req;
      logic [3:0] opa, opb, op;
      logic [7:0] a1, a2, b1, b2, i1, i2, exp_res;
      for (int t = 0; t < 24; t++) begin
         req = 2'($urandom_range(1, 3));
         opa = 4'($urandom); opb = 4'($urandom);
         a1 = 8'($urandom); a2 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
         exp_b = (req == 2'b10) ? 1'b1 : (req == 2'b01) ? 1'b0 : tie_winner();
         op = exp_b ? opb : opa; i1 = exp_b ? b1 : a1; i2 = exp_b ? b2 : a2;
         legal = (op <= 4'd9);
         n = ref_n(op, i2);
         exp_res = legal ? ref_alu(op, i1, i2) : prev_res;
         do_txn(req, opa, opb, a1, a2, b1, b2, 0, ack_at, win_b, n_ack, steps, clrs, done_at, lat_bad);
         checks++;
         if (ack_at !== 0 || win_b !== exp_b) begin
            failures++; $display("FAIL b2b_grant t=%0d ack=%0d b=%0d exp=0/%0d", t, ack_at, win_b, exp_b);
         end
         checks++;
         if (steps !== n || done_at !== n + 3) begin
            failures++; $display("FAIL b2b_timing t=%0d op=%0d steps=%0d done=%0d exp=%0d/%0d", t, op, steps, done_at, n, n + 3);
         end
         checks++;
         if ({Result, ResultId, Err} !== {exp_res, exp_b, !legal}) begin
            failures++; $display("FAIL b2b_result t=%0d got=%h/%b/%b exp=%h/%b/%b", t, Result, ResultId, Err, exp_res, exp_b, !legal);
         end
         checks++;
         if (n_ack !== 1 || clrs !== 1 || lat_bad) begin
            failures++; $display("FAIL b2b_ctrl t=%0d acks=%0d clrs=%0d latch_bad=%0d exp=1/1/0", t, n_ack, clrs, lat_bad);
         end
         last_b = exp_b; prev_res = exp_res;
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_illegal();
      test_shift();
      test_arb();
      test_drop();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not reach the summary");
      $fatal(1, "watchdog");
   end

endmodule
